// File: rtl/multiplier_factor_search.sv
// Sequential factor search: walks every pair (a,b) with a,b >= 2, multiplies them
// with a shift-add datapath and reports the first (or counts every) pair with a*b == target.
module multiplier_factor_search #(
    parameter int unsigned AW        = 4,
    parameter int unsigned BW        = 3,
    parameter bit          COUNT_ALL = 1'b0,
    localparam int unsigned NW       = AW + BW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [NW-1:0] target,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [AW-1:0] a_out,
    output logic [BW-1:0] b_out,
    output logic [NW-1:0] match_count
);

    localparam int unsigned KW = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] target_q, target_d;
    logic [AW-1:0] a_q, a_d;
    logic [BW-1:0] b_q, b_d;
    logic [NW-1:0] acc_q, acc_d;
    logic [KW-1:0] k_q, k_d;
    logic          done_q, done_d;
    logic          found_q, found_d;
    logic [AW-1:0] a_out_q, a_out_d;
    logic [BW-1:0] b_out_q, b_out_d;
    logic [NW-1:0] count_q, count_d;

    logic          hit;
    logic          last_pair;
    logic [NW-1:0] a_ext;

    assign a_ext     = {{BW{1'b0}}, a_q};
    assign hit       = (acc_q == target_q);
    assign last_pair = (a_q == '1) && (b_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            a_out_q  <= '0;
            b_out_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            done_q   <= done_d;
            found_q  <= found_d;
            a_out_q  <= a_out_d;
            b_out_q  <= b_out_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        k_d      = k_q;
        done_d   = done_q;
        found_d  = found_q;
        a_out_d  = a_out_q;
        b_out_d  = b_out_q;
        count_d  = count_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = target;
                    done_d   = 1'b0;
                    found_d  = 1'b0;
                    a_out_d  = '0;
                    b_out_d  = '0;
                    count_d  = '0;
                    a_d      = AW'(2);
                    b_d      = BW'(2);
                    acc_d    = '0;
                    k_d      = '0;
                    // No pair with both factors >= 2 can produce 0..3.
                    if (target < NW'(4)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = MUL;
                    end
                end
            end

            MUL: begin
                if (abort) begin
                    state_d = IDLE;
                    found_d = 1'b0;
                    a_out_d = '0;
                    b_out_d = '0;
                    count_d = '0;
                end else begin
                    if (b_q[k_q]) begin
                        acc_d = acc_q + (a_ext << k_q);
                    end
                    if (k_q == KW'(BW - 1)) begin
                        k_d     = '0;
                        state_d = CHECK;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end

            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                    found_d = 1'b0;
                    a_out_d = '0;
                    b_out_d = '0;
                    count_d = '0;
                end else begin
                    if (hit) begin
                        count_d = count_q + NW'(1);
                        if (!found_q) begin
                            found_d = 1'b1;
                            a_out_d = a_q;
                            b_out_d = b_q;
                        end
                    end
                    if ((!COUNT_ALL && hit) || last_pair) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        // b is the inner loop; it wraps back to 2 when a advances.
                        if (b_q == '1) begin
                            b_d = BW'(2);
                            a_d = a_q + AW'(1);
                        end else begin
                            b_d = b_q + BW'(1);
                        end
                        acc_d   = '0;
                        state_d = MUL;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == MUL) || (state_q == CHECK);
    assign done        = done_q;
    assign found       = found_q;
    assign a_out       = a_out_q;
    assign b_out       = b_out_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_multiplier_factor_search.sv
// Directed and table-driven checks of multiplier_factor_search, plus a small
// software-model comparison for a wider COUNT_ALL=1 instance.
module tb_multiplier_factor_search;

    logic clk;
    logic rst_n;

    // dut0: AW=4 BW=3 COUNT_ALL=0
    logic       start0, abort0, busy0, done0, found0;
    logic [6:0] target0, cnt0;
    logic [3:0] a0;
    logic [2:0] b0;
    // dut1: AW=4 BW=3 COUNT_ALL=1
    logic       start1, abort1, busy1, done1, found1;
    logic [6:0] target1, cnt1;
    logic [3:0] a1;
    logic [2:0] b1;
    // dut2: AW=5 BW=4 COUNT_ALL=1
    logic       start2, abort2, busy2, done2, found2;
    logic [8:0] target2, cnt2;
    logic [4:0] a2;
    logic [3:0] b2;

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;

    logic       busy_m, done_m, found_m;
    logic [4:0] a_m;
    logic [3:0] b_m;
    logic [8:0] cnt_m;

    multiplier_factor_search #(.AW(4), .BW(3), .COUNT_ALL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .target(target0),
        .busy(busy0), .done(done0), .found(found0), .a_out(a0), .b_out(b0),
        .match_count(cnt0)
    );
    multiplier_factor_search #(.AW(4), .BW(3), .COUNT_ALL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .target(target1),
        .busy(busy1), .done(done1), .found(found1), .a_out(a1), .b_out(b1),
        .match_count(cnt1)
    );
    multiplier_factor_search #(.AW(5), .BW(4), .COUNT_ALL(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .target(target2),
        .busy(busy2), .done(done2), .found(found2), .a_out(a2), .b_out(b2),
        .match_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        busy_m = busy0; done_m = done0; found_m = found0;
        a_m = {1'b0, a0}; b_m = {1'b0, b0}; cnt_m = {2'b0, cnt0};
        if (sel == 1) begin
            busy_m = busy1; done_m = done1; found_m = found1;
            a_m = {1'b0, a1}; b_m = {1'b0, b1}; cnt_m = {2'b0, cnt1};
        end else if (sel == 2) begin
            busy_m = busy2; done_m = done2; found_m = found2;
            a_m = a2; b_m = b2; cnt_m = cnt2;
        end
    end

    typedef struct {
        int sel;
        int target;
        int found;
        int a;
        int b;
        int cnt;
        int lat;   // rising edges after the accepting edge; 0 = done on that edge
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit st, input bit ab, input int t);
        case (sel)
            0: begin start0 = st; abort0 = ab; target0 = t[6:0]; end
            1: begin start1 = st; abort1 = ab; target1 = t[6:0]; end
            default: begin start2 = st; abort2 = ab; target2 = t[8:0]; end
        endcase
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (!done_m && lat < 5000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("%s done_seen", tag), int'(done_m), 1);
    endtask

    // Accept a start (optionally with abort asserted alongside) and wait for done.
    task automatic run_search(input int s, input int t, input bit with_abort,
                              input string tag, output int lat);
        sel = s;
        @(negedge clk);
        drive(1'b1, with_abort, t);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, t);
        chk($sformatf("%s busy_after_start", tag), int'(busy_m), (t >= 4) ? 1 : 0);
        wait_done(tag, lat);
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_found,
                                input int exp_a, input int exp_b, input int exp_cnt,
                                input int exp_lat);
        chk($sformatf("%s latency", tag), lat, exp_lat);
        chk($sformatf("%s found", tag), int'(found_m), exp_found);
        chk($sformatf("%s a_out", tag), int'(a_m), exp_a);
        chk($sformatf("%s b_out", tag), int'(b_m), exp_b);
        chk($sformatf("%s match_count", tag), int'(cnt_m), exp_cnt);
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("%s done_held", tag), int'(done_m), 1);
        chk($sformatf("%s busy_after_done", tag), int'(busy_m), 0);
    endtask

    // Exhaustive count over the dut2 pair space.
    task automatic model2(input int t, output int cnt, output int fa, output int fb);
        cnt = 0; fa = 0; fb = 0;
        for (int a = 2; a <= 31; a++) begin
            for (int b = 2; b <= 15; b++) begin
                if (a * b == t) begin
                    if (cnt == 0) begin fa = a; fb = b; end
                    cnt++;
                end
            end
        end
    endtask

    initial begin
        int lat;
        int mc, mfa, mfb, t;

        vecs[0]  = '{0,  17, 0,  0, 0, 0, 336};
        vecs[1]  = '{0,  15, 1,  3, 5, 1,  40};
        vecs[2]  = '{1,  12, 1,  2, 6, 4, 336};
        vecs[3]  = '{0,   3, 0,  0, 0, 0,   0};
        vecs[4]  = '{0, 105, 1, 15, 7, 1, 336};
        vecs[5]  = '{0,   6, 1,  2, 3, 1,   8};
        vecs[6]  = '{0,   4, 1,  2, 2, 1,   4};
        vecs[7]  = '{0,   0, 0,  0, 0, 0,   0};
        vecs[8]  = '{0, 127, 0,  0, 0, 0, 336};
        vecs[9]  = '{1, 105, 1, 15, 7, 1, 336};
        vecs[10] = '{1,  17, 0,  0, 0, 0, 336};
        vecs[11] = '{1,   4, 1,  2, 2, 1, 336};
        vecs[12] = '{1,  30, 1,  5, 6, 4, 336};
        vecs[13] = '{1,   2, 0,  0, 0, 0,   0};

        rst_n = 1'b0;
        start0 = 0; abort0 = 0; target0 = '0;
        start1 = 0; abort1 = 0; target1 = '0;
        start2 = 0; abort2 = 0; target2 = '0;

        #12;
        chk("reset busy0", int'(busy0), 0);
        chk("reset done0", int'(done0), 0);
        chk("reset found0", int'(found0), 0);
        chk("reset a0", int'(a0), 0);
        chk("reset b0", int'(b0), 0);
        chk("reset cnt0", int'(cnt0), 0);
        chk("reset done1", int'(done1), 0);
        chk("reset done2", int'(done2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d(t=%0d)", i, vecs[i].target);
            run_search(vecs[i].sel, vecs[i].target, 1'b0, tag, lat);
            check_result(tag, lat, vecs[i].found, vecs[i].a, vecs[i].b,
                         vecs[i].cnt, vecs[i].lat);
        end

        // abort while idle with a result held: no effect
        sel = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 0);
        chk("idle_abort done", int'(done_m), 1);
        chk("idle_abort found", int'(found_m), 0);

        // abort mid-search on dut0, then restart identically
        sel = 0;
        @(negedge clk);
        drive(1'b1, 1'b0, 15);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 15);
        repeat (19) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 15);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 15);
        chk("abort0 busy", int'(busy_m), 0);
        chk("abort0 done", int'(done_m), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort0 stays_idle", int'(busy_m), 0);

        // start pulsed while busy must be ignored
        @(negedge clk);
        drive(1'b1, 1'b0, 15);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 15);
        repeat (4) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 6);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 6);
        wait_done("restart15", lat);
        check_result("restart15", lat + 5, 1, 3, 5, 1, 40);

        // abort after a match on dut1 discards the partial result
        sel = 1;
        @(negedge clk);
        drive(1'b1, 1'b0, 12);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 12);
        repeat (29) @(posedge clk);
        #1;
        chk("abort1 pre found", int'(found_m), 1);
        chk("abort1 pre cnt", int'(cnt_m), 1);
        @(negedge clk);
        drive(1'b0, 1'b1, 12);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 12);
        chk("abort1 busy", int'(busy_m), 0);
        chk("abort1 done", int'(done_m), 0);
        chk("abort1 found", int'(found_m), 0);
        chk("abort1 a_out", int'(a_m), 0);
        chk("abort1 b_out", int'(b_m), 0);
        chk("abort1 cnt", int'(cnt_m), 0);

        // start and abort together in IDLE: start wins
        run_search(0, 6, 1'b1, "start_abort", lat);
        check_result("start_abort", lat, 1, 2, 3, 1, 8);

        // asynchronous reset mid-search, then a clean rerun
        sel = 0;
        @(negedge clk);
        drive(1'b1, 1'b0, 17);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 17);
        repeat (99) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset busy", int'(busy0), 0);
        chk("midreset done", int'(done0), 0);
        chk("midreset found", int'(found0), 0);
        chk("midreset a", int'(a0), 0);
        chk("midreset b", int'(b0), 0);
        chk("midreset cnt", int'(cnt0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_search(0, 17, 1'b0, "after_reset17", lat);
        check_result("after_reset17", lat, 0, 0, 0, 0, 336);

        // wider instance against the software count
        for (int i = 0; i < 24; i++) begin
            string tag;
            if (i % 2 == 1) t = int'($urandom_range(2, 31)) * int'($urandom_range(2, 15));
            else            t = int'($urandom_range(0, 511));
            if (i == 0) t = 1;
            model2(t, mc, mfa, mfb);
            tag = $sformatf("rand%0d(t=%0d)", i, t);
            run_search(2, t, 1'b0, tag, lat);
            check_result(tag, lat, (mc > 0) ? 1 : 0, mfa, mfb, mc, (t < 4) ? 0 : 2100);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
